// File: rtl/user_proj_count_monitor.sv
// Receive-side checker for the 2-bit GPIO ripple counter, with Wishbone stats access.
// Define COUNT_MON_IRQ_EN to add irq[2:0] with per-event enables in CTRL[3:2].
module user_proj_count_monitor #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned STEP_W    = 32,
    parameter int unsigned EVT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [1:0]  io_in,
`ifdef COUNT_MON_IRQ_EN
    output logic [2:0]  irq,
`endif
    output logic [1:0]  io_oeb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } state_t;

    logic [1:0]        rst_pipe;
    logic              rst;
    logic [1:0]        stage1;
    logic [1:0]        stage2;
    logic [1:0]        s;
    logic [1:0]        last;
    logic [1:0]        last_inc;
    state_t            state;
    state_t            state_nx;
    logic              en;
    logic              clr;
    logic              tracking;
    logic              moved;
    logic              step;
    logic              bad;
    logic              wrap;
    logic [STEP_W-1:0] steps;
    logic [EVT_W-1:0]  wraps;
    logic [EVT_W-1:0]  errs;
    logic              err;
    logic              hit;
    logic              req;
    logic              ctrl_wr;
    logic [2:0]        idx;
    logic [31:0]       ctrl_rd;
    logic [31:0]       rdata;
    logic              unused;

    assign io_oeb = 2'b11;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) rst_pipe <= 2'b11;
        else          rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst = rst_pipe[1];

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            stage1 <= 2'b00;
            stage2 <= 2'b00;
            s      <= 2'b00;
        end else begin
            stage1 <= io_in;
            stage2 <= stage1;
            s      <= stage2;
        end
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = SYNC;
            SYNC:    state_nx = en ? TRACK : IDLE;
            TRACK:   if (!en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // stage2 is the value s takes on this edge; events are judged against it.
    assign last_inc = last + 2'd1;
    assign tracking = (state == TRACK) && en;
    assign moved    = tracking && (stage2 != last);
    assign step     = moved && (stage2 == last_inc);
    assign bad      = moved && !step;
    assign wrap     = step && (last == 2'd3);

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst)                       last <= 2'b00;
        else if (state == SYNC && en)  last <= s;
        else if (tracking)             last <= stage2;
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            steps <= '0;
            wraps <= '0;
            errs  <= '0;
            err   <= 1'b0;
        end else if (clr) begin
            steps <= '0;
            wraps <= '0;
            errs  <= '0;
            err   <= 1'b0;
        end else begin
            if (step && steps != '1) steps <= steps + STEP_W'(1);
            if (wrap && wraps != '1) wraps <= wraps + EVT_W'(1);
            if (bad && errs != '1)   errs  <= errs + EVT_W'(1);
            if (bad)                 err   <= 1'b1;
        end
    end

    assign hit = wbs_cyc_i && wbs_stb_i
              && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req     = hit && !wbs_ack_o;
    assign idx     = wbs_adr_i[4:2];
    assign ctrl_wr = req && wbs_we_i && (idx == 3'd0) && wbs_sel_i[0];

`ifdef COUNT_MON_IRQ_EN
    logic [1:0] ie;
    logic [1:0] irq_q;

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            en  <= 1'b0;
            clr <= 1'b0;
            ie  <= 2'b00;
        end else begin
            clr <= 1'b0;
            if (ctrl_wr) begin
                en  <= wbs_dat_i[0];
                clr <= wbs_dat_i[1];
                ie  <= wbs_dat_i[3:2];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            irq_q <= 2'b00;
        end else begin
            irq_q[0] <= ie[0] && !clr && bad && (errs != '1);
            irq_q[1] <= ie[1] && !clr && wrap && (wraps != '1);
        end
    end

    assign irq     = {1'b0, irq_q};
    assign ctrl_rd = {28'd0, ie, 1'b0, en};
    assign unused  = ^{wbs_sel_i[3:1], wbs_adr_i[7:5],
                       wbs_adr_i[1:0], wbs_dat_i[31:4]};
`else
    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            en  <= 1'b0;
            clr <= 1'b0;
        end else begin
            clr <= 1'b0;
            if (ctrl_wr) begin
                en  <= wbs_dat_i[0];
                clr <= wbs_dat_i[1];
            end
        end
    end

    assign ctrl_rd = {31'd0, en};
    assign unused  = ^{wbs_sel_i[3:1], wbs_adr_i[7:5],
                       wbs_adr_i[1:0], wbs_dat_i[31:2]};
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0:    rdata = ctrl_rd;
            3'd1:    rdata = {27'd0, err, last, state};
            3'd2:    rdata = 32'(steps);
            3'd3:    rdata = 32'(wraps);
            3'd4:    rdata = 32'(errs);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_user_proj_count_monitor.sv
// Scoreboard bench for user_proj_count_monitor: random counter traffic vs a step model.
// Expected reads are queued by the driver and checked by an ack monitor.
module tb_user_proj_count_monitor;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int SW = 4;
    localparam int EW = 4;
`ifdef COUNT_MON_IRQ_EN
    localparam logic [31:0] IE = 32'h4;
`else
    localparam logic [31:0] IE = 32'h0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        cyc  = 1'b0;
    logic        stb  = 1'b0;
    logic        we   = 1'b0;
    logic [3:0]  sel  = 4'h0;
    logic [31:0] adr  = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [1:0]  io   = 2'b00;
    logic [1:0]  oeb;
`ifdef COUNT_MON_IRQ_EN
    logic [2:0]  irq;
`endif

    always #5 clk = ~clk;

    user_proj_count_monitor #(
        .BASE_ADDR(BASE),
        .STEP_W(SW),
        .EVT_W(EW)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .io_in    (io),
`ifdef COUNT_MON_IRQ_EN
        .irq      (irq),
`endif
        .io_oeb   (oeb)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int         m_steps = 0;
    int         m_wraps = 0;
    int         m_errs  = 0;
    bit         m_err   = 1'b0;
    bit         m_en    = 1'b0;
    logic [1:0] m_last  = 2'b00;
    logic [1:0] m_ie    = 2'b00;
    logic [1:0] cur_io  = 2'b00;
    int         m_irq0  = 0;
    int         irq0_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", {31'd0, ack}, 32'd0);
            end else begin
                e = sbq.pop_front();
                if (e.is_rd) check(e.name, rdat, e.exp);
            end
        end
`ifdef COUNT_MON_IRQ_EN
        if (irq[0] === 1'b1) irq0_cnt++;
`endif
    end

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Rule model: each change is classified by its distance mod 4 from the previous value.
    task automatic apply_val(input logic [1:0] v);
        int d;
        if (m_en) begin
            d = (int'(v) - int'(m_last) + 4) % 4;
            if (d == 1) begin
                m_steps = sat(m_steps + 1, SW);
                if (m_last == 2'd3) m_wraps = sat(m_wraps + 1, EW);
            end else if (d != 0) begin
                if (m_ie[0] && m_errs < (1 << EW) - 1) m_irq0++;
                m_errs = sat(m_errs + 1, EW);
                m_err  = 1'b1;
            end
            m_last = v;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input bit want, input logic [31:0] exp,
                       input string name);
        exp_t e;
        bit   got;
        got = 1'b0;
        if (want) begin
            e.is_rd = !w;
            e.exp   = exp;
            e.name  = name;
            sbq.push_back(e);
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check({name, "_ack"}, {31'd0, got}, {31'd0, want});
        if (want && !got) void'(sbq.pop_back());
        idle(1);
    endtask

    task automatic rd(input int i, input logic [31:0] exp, input string name);
        bus(1'b0, BASE + 32'(i * 4), '0, 4'hF, 1'b1, exp, name);
    endtask

    task automatic wr(input int i, input logic [31:0] d, input logic [3:0] s);
        bus(1'b1, BASE + 32'(i * 4), d, s, 1'b1, '0, "wr");
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        wr(0, d, 4'h1);
        if (d[0] && !m_en) m_last = cur_io;
        m_en = d[0];
`ifdef COUNT_MON_IRQ_EN
        m_ie = d[3:2];
`endif
        if (d[1]) begin
            m_steps = 0; m_wraps = 0; m_errs = 0; m_err = 1'b0;
        end
    endtask

    task automatic drive(input logic [1:0] v, input int hold);
        io = v;
        cur_io = v;
        apply_val(v);
        idle(hold);
    endtask

    task automatic check_all(input string tag);
        rd(0, {28'd0, m_ie, 1'b0, m_en}, {tag, ".ctrl"});
        rd(1, {27'd0, m_err, m_last, (m_en ? 2'd2 : 2'd0)}, {tag, ".status"});
        rd(2, 32'(m_steps), {tag, ".steps"});
        rd(3, 32'(m_wraps), {tag, ".wraps"});
        rd(4, 32'(m_errs), {tag, ".errs"});
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0] nv;
        bit         got;

        rst = 1'b1;
        idle(3);
        check("oeb_in_reset", {30'd0, oeb}, 32'd3);
        check("ack_in_reset", {31'd0, ack}, 32'd0);
        rst = 1'b0;
        idle(4);
        check_all("reset");
        check("oeb", {30'd0, oeb}, 32'd3);

        // Clean count sequence with one wrap.
        wr_ctrl(32'h3);
        idle(3);
        drive(2'd0, 8); drive(2'd1, 8); drive(2'd2, 8);
        drive(2'd3, 8); drive(2'd0, 8); drive(2'd1, 8);
        idle(5);
        check_all("seq");

        // Illegal jump then a legal step.
        wr_ctrl(32'h0);
        drive(2'd0, 8);
        wr_ctrl(32'h3 | IE);
        idle(3);
        drive(2'd2, 8);
        idle(5);
        check_all("jump");
        drive(2'd3, 8);
        idle(5);
        check_all("after_jump");
`ifdef COUNT_MON_IRQ_EN
        check("irq0_pulses", 32'(irq0_cnt), 32'(m_irq0));
`endif

        // Clear lands on the same edge as a step.
        drive(2'd0, 1);
        wr_ctrl(32'h3 | IE);
        idle(5);
        check_all("clr_race");

        // Register map corners.
        wr(0, 32'h0, 4'hE);
        rd(0, {28'd0, m_ie, 1'b0, m_en}, "ctrl_sel0_ignored");
        rd(6, 32'd0, "idx6");
        wr(7, 32'hFFFF_FFFF, 4'hF);
        rd(5, 32'd0, "idx5");
        bus(1'b0, 32'h3000_0108, '0, 4'hF, 1'b0, '0, "miss_rd");
        bus(1'b1, 32'h2000_0000, 32'h1, 4'hF, 1'b0, '0, "miss_wr");

        // Saturation of steps and wraps.
        wr_ctrl(32'h3 | IE);
        idle(3);
        for (int i = 0; i < 70; i++) begin
            nv = cur_io + 2'd1;
            drive(nv, 2);
        end
        idle(5);
        check_all("sat_steps");

        // Saturation of errs.
        wr_ctrl(32'h3 | IE);
        idle(3);
        for (int i = 0; i < 20; i++) begin
            nv = cur_io + 2'd2;
            drive(nv, 2);
        end
        idle(5);
        check_all("sat_errs");

        // Random traffic, cleared at the start of each block.
        for (int b = 0; b < 4; b++) begin
            wr_ctrl(32'h3 | IE);
            idle(3);
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 99) < 70) nv = cur_io + 2'd1;
                else                            nv = 2'($urandom_range(0, 3));
                drive(nv, int'($urandom_range(1, 4)));
            end
            idle(5);
            check_all($sformatf("rand%0d", b));
            if (b == 1) begin
                wr_ctrl(32'h0 | IE);
                for (int i = 0; i < 10; i++)
                    drive(2'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
                idle(5);
                check_all("disabled");
                wr_ctrl(32'h1 | IE);
                idle(3);
                for (int i = 0; i < 10; i++)
                    drive(2'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
                idle(5);
                check_all("reenabled");
            end
        end
`ifdef COUNT_MON_IRQ_EN
        check("irq0_total", 32'(irq0_cnt), 32'(m_irq0));
`endif

        // Reset between strobe and acknowledge.
        got = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'h0; sel = 4'h1;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack) got = 1'b1;
        end
        check("rst_mid_xfer_ack", {31'd0, got}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        idle(4);
        m_steps = 0; m_wraps = 0; m_errs = 0; m_err = 1'b0;
        m_en = 1'b0; m_last = 2'b00; m_ie = 2'b00;
        check_all("post_reset");

        idle(3);
        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
